// File: rtl/apb_pkg.sv
// Shared types and constants for the APB memory slave.
package apb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } apb_slv_state_e;

  localparam logic APB_RESP_OKAY = 1'b0;
  localparam logic APB_RESP_ERR  = 1'b1;

  function automatic int strb_width(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/apb_mem_slave_if.sv
// APB4 bus bundle between a bridge (master) and the memory slave.
interface apb_mem_slave_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  import apb_pkg::*;

  localparam int STRB_W = strb_width(DATA_WIDTH);

  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic [STRB_W-1:0]     PSTRB;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    output PRDATA, PREADY, PSLVERR
  );

endinterface

// File: rtl/apb_mem_slave_ram.sv
// Storage array with per-byte write enables and a registered read port.
module apb_bytewen_ram
  import apb_pkg::*;
#(
  parameter int DEPTH      = 256,
  parameter int DATA_WIDTH = 32,
  parameter int IDX_WIDTH  = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             rd_en,
  input  logic                             rd_clr,
  input  logic [IDX_WIDTH-1:0]             rd_idx,
  output logic [DATA_WIDTH-1:0]            rd_data,
  input  logic                             wr_en,
  input  logic [IDX_WIDTH-1:0]             wr_idx,
  input  logic [DATA_WIDTH-1:0]            wr_data,
  input  logic [strb_width(DATA_WIDTH)-1:0] wr_strb
);
  localparam int STRB_W = strb_width(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wr_strb[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  // The read register doubles as the bus read-data holding register.
  always_ff @(posedge clk) begin
    if (!rst_n)     rd_data <= '0;
    else if (rd_en) rd_data <= rd_clr ? '0 : mem[rd_idx];
  end

endmodule

// File: rtl/apb_mem_slave.sv
// APB4 memory slave: address decode, wait-state counter and IDLE/ACCESS FSM in front of a byte-writable RAM.
module apb_mem_slave
  import apb_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    DEPTH       = 256,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int                    WAIT_STATES = 0
) (
  input logic            PCLK,
  input logic            PRESETn,
  apb_mem_slave_if.slave bus
);
  localparam int STRB_W    = strb_width(DATA_WIDTH);
  localparam int LANE_BITS = $clog2(STRB_W);
  localparam int CNT_W     = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam int IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  apb_slv_state_e state, state_next;
  logic [CNT_W-1:0]      cnt;
  logic                  err_q;
  logic [IDX_W-1:0]      idx_q;
  logic [ADDR_WIDTH-1:0] offset;
  logic [ADDR_WIDTH-1:0] word;
  logic [IDX_W-1:0]      idx_d;
  logic                  addr_err;
  logic                  setup;
  logic                  ready;
  logic                  wr_en;

  assign offset   = bus.PADDR - BASE_ADDR;
  assign word     = offset >> LANE_BITS;
  assign addr_err = (bus.PADDR < BASE_ADDR)
                 || (word >= ADDR_WIDTH'(DEPTH))
                 || ((offset & ADDR_WIDTH'(STRB_W - 1)) != '0);
  assign idx_d    = word[IDX_W-1:0];
  assign setup    = (state == IDLE) && bus.PSEL && !bus.PENABLE;

  always_ff @(posedge PCLK) begin
    if (!PRESETn) state <= IDLE;
    else          state <= state_next;
  end

  // Dropping PSEL mid-access abandons the transfer without a response.
  always_comb begin
    state_next = state;
    ready      = 1'b0;
    case (state)
      IDLE: begin
        if (setup) state_next = ACCESS;
      end
      ACCESS: begin
        ready = (cnt == '0);
        if ((cnt == '0) || !bus.PSEL) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      cnt   <= '0;
      err_q <= APB_RESP_OKAY;
      idx_q <= '0;
    end else if (setup) begin
      cnt   <= CNT_W'(WAIT_STATES);
      err_q <= addr_err ? APB_RESP_ERR : APB_RESP_OKAY;
      idx_q <= idx_d;
    end else if ((state == ACCESS) && bus.PSEL && bus.PENABLE && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign bus.PREADY  = ready;
  assign bus.PSLVERR = ready ? err_q : APB_RESP_OKAY;

  // Reset on the completion edge must still suppress the commit.
  assign wr_en = ready && bus.PSEL && bus.PENABLE && bus.PWRITE
              && (err_q == APB_RESP_OKAY) && PRESETn;

  apb_bytewen_ram #(
    .DEPTH     (DEPTH),
    .DATA_WIDTH(DATA_WIDTH),
    .IDX_WIDTH (IDX_W)
  ) u_ram (
    .clk    (PCLK),
    .rst_n  (PRESETn),
    .rd_en  (setup && !bus.PWRITE),
    .rd_clr (addr_err),
    .rd_idx (idx_d),
    .rd_data(bus.PRDATA),
    .wr_en  (wr_en),
    .wr_idx (idx_q),
    .wr_data(bus.PWDATA),
    .wr_strb(bus.PSTRB)
  );

endmodule

// File: doc/apb_mem_slave.md
Name: apb_mem_slave

Overview:
Parametrised APB4 memory-mapped slave. Generalises the fixed 32x256 APB memory slave in data width, depth and base address. Adds byte-lane write strobes (PSTRB), error response (PSLVERR) and a configurable wait-state count. It sits behind the APB bridge as a scratch RAM / register window for peripheral subsystems.

Parameters:
- ADDR_WIDTH, 32: PADDR width.
- DATA_WIDTH, 32: PWDATA/PRDATA width. Legal values are 8, 16, 32, 64.
- DEPTH, 256: number of DATA_WIDTH words. Need not be a power of two.
- BASE_ADDR, 0: byte address of word 0. Must be aligned to DATA_WIDTH/8.
- WAIT_STATES, 0: extra access-phase cycles before PREADY. Legal range is 0..15.

Ports:
- PCLK  in  1  clock; all logic on the rising edge.
- PRESETn  in  1  synchronous active-low reset.
- PSEL  in  1  slave select.
- PENABLE  in  1  access phase indicator.
- PWRITE  in  1  1 = write, 0 = read.
- PADDR  in  ADDR_WIDTH  byte address.
- PWDATA  in  DATA_WIDTH  write data.
- PSTRB  in  DATA_WIDTH/8  write byte-lane enables.
- PRDATA  out  DATA_WIDTH  read data.
- PREADY  out  1  transfer completes this cycle.
- PSLVERR  out  1  error response; valid only while PREADY=1.

Behaviour:
- Reset (PRESETn=0 at a PCLK edge):
  - state goes to IDLE; wait counter goes to 0.
  - PRDATA=0, PREADY=0, PSLVERR=0 from the next cycle.
  - Memory contents are not reset and are undefined.
  - Reset asserted mid-transfer aborts it; any pending write is not committed.
- Address decode:
  - offset = PADDR - BASE_ADDR; index = offset / (DATA_WIDTH/8).
  - Error if PADDR < BASE_ADDR, or index >= DEPTH, or the offset low log2(DATA_WIDTH/8) bits are nonzero.
- FSM states: IDLE, ACCESS.
  - IDLE to ACCESS on a setup phase (PSEL=1, PENABLE=0).
    - In that cycle the slave latches the error flag and index, and loads counter = WAIT_STATES.
    - For a read it registers PRDATA <= error ? 0 : mem[index].
    - For a write, PRDATA holds its last value.
  - ACCESS while counter != 0: PREADY=0; counter decrements each cycle PSEL=1 and PENABLE=1.
  - ACCESS with counter == 0: PREADY=1 and PSLVERR = latched error flag. Next state is IDLE.
- PREADY and PSLVERR are decoded from state/counter/flag registers only, with no combinational path from inputs.
- Access phase lasts WAIT_STATES+1 cycles. A zero-wait transfer is therefore 2 cycles: setup + access.
- Write commit happens on the completion cycle (PREADY=1, PSEL=1, PENABLE=1, PWRITE=1, no error).
  - Byte lane b of mem[index] <= PWDATA lane b only where PSTRB[b]=1.
  - PSTRB=0 is a legal no-op with an OKAY response.
- Erroring writes never modify memory. Erroring reads return PRDATA=0.
- PSTRB is ignored on reads.
- Back-to-back transfers: a setup phase in the cycle after completion is accepted from IDLE with no dead cycle.
- PSEL dropped while in ACCESS: the transfer is aborted and state returns to IDLE next cycle. No write, PREADY stays 0.
- PENABLE=1 seen in IDLE (no setup phase): ignored, and the FSM stays IDLE.
- Counter width is max(1, $clog2(WAIT_STATES+1)).

Decomposition:
- Package apb_pkg holds:
  - state enum apb_slv_state_e {IDLE, ACCESS};
  - constants APB_RESP_OKAY=1'b0 and APB_RESP_ERR=1'b1;
  - helper function strb_width(DATA_WIDTH).
- One sub-module, apb_bytewen_ram (DEPTH x DATA_WIDTH, synchronous read, per-byte write enable), holds the storage array.
- The top level keeps the FSM, decode and counter.

Test Plan:
- Zero-wait write/read, DATA_WIDTH=32, BASE_ADDR=0x1000, WAIT_STATES=0: write 0xDEADBEEF to 0x1004 with PSTRB=4'hF, then read 0x1004 -> PREADY high on the 2nd cycle of each transfer, PRDATA=0xDEADBEEF, PSLVERR=0.
- Byte strobes: write 0x11223344 with PSTRB=4'hF, then 0xAABBCCDD with PSTRB=4'b0101 to the same address, then read -> 0x11BB33DD.
- Wait states, WAIT_STATES=3: read -> PREADY low for 3 access cycles and high on the 4th. Total transfer is 5 cycles, and PRDATA is correct when PREADY=1.
- Errors: read at BASE_ADDR+DEPTH*4, write to 0x1002 (misaligned), access at 0x0FFC -> each gives PSLVERR=1 with PREADY=1 and PRDATA=0 on the read; a follow-up read shows the targeted in-range memory is unchanged.
- Back-to-back and abort: two writes with no idle cycle between them -> both commit. A write with WAIT_STATES=2 where PSEL drops after 1 access cycle -> no commit, and a read back returns the old data.
- Reset mid-transfer: PRESETn=0 during the ACCESS of a write with WAIT_STATES=2 -> at the next edge PREADY=0, PSLVERR=0, PRDATA=0, state is IDLE, and the write is not committed.
